// File: rtl/frame_pixel_scheduler.sv
// rtl/frame_pixel_scheduler.sv - raster walker issuing engine requests and streaming buffered RGB results
// Credits bound outstanding requests to the FIFO depth, since the engine cannot be stalled.
module frame_pixel_scheduler #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int DEPTH = 8
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [11:0] req_x,
    output logic [11:0] req_y,
    input  logic        pix_valid,
    input  logic [23:0] pix_rgb,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [11:0]   H_LAST  = 12'(H_RES - 1);
    localparam logic [11:0]   V_LAST  = 12'(V_RES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [11:0]     rx_q, rx_d, ry_q, ry_d, ox_q, ox_d, oy_q, oy_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic [23:0]     mem_q [DEPTH];

    logic req_hs, out_hs, full, push_ok, last_req, last_out;

    assign req_hs   = req_valid && req_ready;
    assign out_hs   = m_axis_tvalid && m_axis_tready;
    assign full     = (count_q == DEPTH_C);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok  = pix_valid && (!full || out_hs);
    assign last_req = (rx_q == H_LAST) && (ry_q == V_LAST);
    assign last_out = (ox_q == H_LAST) && (oy_q == V_LAST);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (req_hs && last_req) state_d = S_DRAIN;
            S_DRAIN: if (out_hs && last_out) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
        req_valid  = (state_q == S_RUN) && (credits_q != '0);
    end

    always_comb begin
        rx_d = rx_q;
        ry_d = ry_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (state_q == S_IDLE && start) begin
            rx_d = '0;
            ry_d = '0;
            ox_d = '0;
            oy_d = '0;
        end else begin
            if (req_hs) begin
                if (rx_q == H_LAST) begin
                    rx_d = '0;
                    ry_d = ry_q + 12'd1;
                end else begin
                    rx_d = rx_q + 12'd1;
                end
            end
            if (out_hs) begin
                if (ox_q == H_LAST) begin
                    ox_d = '0;
                    oy_d = oy_q + 12'd1;
                end else begin
                    ox_d = ox_q + 12'd1;
                end
            end
        end
    end

    always_comb begin
        credits_d = credits_q;
        if (req_hs && !out_hs)      credits_d = credits_q - CW'(1);
        else if (!req_hs && out_hs) credits_d = credits_q + CW'(1);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (out_hs)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !out_hs)      count_d = count_q + CW'(1);
        else if (!push_ok && out_hs) count_d = count_q - CW'(1);

        ovf_d = ovf_q || (pix_valid && !push_ok);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rx_q      <= '0;
            ry_q      <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            credits_q <= DEPTH_C;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            credits_q <= credits_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage needs no reset: tdata is masked while the FIFO is empty.
    always_ff @(posedge aclk) begin
        if (push_ok) mem_q[wr_ptr_q] <= pix_rgb;
    end

    always_comb begin
        m_axis_tvalid = (count_q != '0);
        m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : 24'h0;
        m_axis_tuser  = m_axis_tvalid && (ox_q == 12'd0) && (oy_q == 12'd0);
        m_axis_tlast  = m_axis_tvalid && (ox_q == H_LAST);
        req_x         = rx_q;
        req_y         = ry_q;
        overflow_err  = ovf_q;
    end
endmodule

// File: tb/tb_frame_pixel_scheduler.sv
// tb/tb_frame_pixel_scheduler.sv - randomized bench with raster-order reference model for frame_pixel_scheduler
module tb_frame_pixel_scheduler;
    localparam int H = 4;
    localparam int V = 3;
    localparam int D = 8;
    localparam int NPIX = H * V;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        busy, frame_done, req_valid;
    logic        req_ready = 1'b0;
    logic [11:0] req_x, req_y;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_rgb = 24'h0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic        overflow_err;

    always #5 aclk = ~aclk;

    frame_pixel_scheduler #(.H_RES(H), .V_RES(V), .DEPTH(D)) dut (
        .aclk(aclk), .areset(areset), .start(start), .busy(busy), .frame_done(frame_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .pix_valid(pix_valid), .pix_rgb(pix_rgb),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .overflow_err(overflow_err)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference state: frame phase (0 idle, 1 active, 2 done), counts of requests/outputs, buffered results.
    int phase = 0, reqs = 0, outs = 0, occ = 0, cyc = 0, lat = 0;
    bit ovf = 0;
    int rr_mode = 1, tr_mode = 1;
    bit start_req = 0, start_on_done = 0, inject = 0;
    int          eq_due[$];
    logic [23:0] eq_rgb[$];
    int d_reqs, d_beats, d_done;
    logic [15:0] tuser_mask, tlast_mask;
    bit          prev_stall = 0;
    logic [25:0] prev_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [23:0] color(input int x, input int y);
        return {8'(x * 7 + 1), 8'(y * 13 + 2), 8'(x ^ y ^ 165)};
    endfunction

    task automatic clear_stats();
        d_reqs = 0; d_beats = 0; d_done = 0; tuser_mask = '0; tlast_mask = '0;
    endtask

    task automatic peek();
        @(posedge aclk);
        #2;
    endtask

    task automatic run_cycle();
        bit exp_rv, exp_tv, req_hs, out_hs, acc;
        @(negedge aclk);
        cyc++;
        exp_rv = (phase == 1) && (reqs < NPIX) && ((reqs - outs) < D);
        exp_tv = (occ > 0);
        chk("busy", busy, phase != 0);
        chk("frame_done", frame_done, phase == 2);
        chk("req_valid", req_valid, exp_rv);
        if (exp_rv) chk("req_xy", {req_x, req_y}, {12'(reqs % H), 12'(reqs / H)});
        chk("tvalid", m_axis_tvalid, exp_tv);
        chk("tdata", m_axis_tdata, exp_tv ? color(outs % H, outs / H) : 24'h0);
        chk("tuser", m_axis_tuser, exp_tv && (outs == 0));
        chk("tlast", m_axis_tlast, exp_tv && (outs % H == H - 1));
        chk("overflow_err", overflow_err, ovf);
        if (prev_stall) chk("stall_hold", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, prev_out);

        req_ready     = (rr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        m_axis_tready = (tr_mode == 1) ? 1'b1 : (tr_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        start         = start_req || (start_on_done && phase == 2);
        start_req     = 0;

        if (req_valid && req_ready) begin
            eq_due.push_back(cyc + lat);
            eq_rgb.push_back(color(int'(req_x), int'(req_y)));
            d_reqs++;
        end
        pix_valid = 1'b0;
        pix_rgb   = 24'h0;
        if (inject) begin
            pix_valid = 1'b1;
            pix_rgb   = 24'($urandom);
            inject    = 0;
        end else if (eq_due.size() > 0 && eq_due[0] == cyc) begin
            pix_valid = 1'b1;
            pix_rgb   = eq_rgb.pop_front();
            void'(eq_due.pop_front());
        end

        if (m_axis_tvalid && m_axis_tready) begin
            if (d_beats < 16) begin
                tuser_mask[d_beats] = m_axis_tuser;
                tlast_mask[d_beats] = m_axis_tlast;
            end
            d_beats++;
        end
        if (frame_done) d_done++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out   = {m_axis_tdata, m_axis_tuser, m_axis_tlast};

        req_hs = exp_rv && req_ready;
        out_hs = exp_tv && m_axis_tready;
        acc = 0;
        if (pix_valid) begin
            if (occ < D || out_hs) acc = 1;
            else ovf = 1;
        end
        occ  = occ + int'(acc) - int'(out_hs);
        reqs = reqs + int'(req_hs);
        outs = outs + int'(out_hs);
        if (phase == 2) phase = 0;
        else if (phase == 1) begin
            if (outs == NPIX) phase = 2;
        end else if (start) begin
            phase = 1; reqs = 0; outs = 0;
        end
    endtask

    task automatic start_frame();
        start_req = 1;
        run_cycle();
    endtask

    task automatic run_until_idle();
        int g = 0;
        do begin
            run_cycle();
            g++;
        end while (phase != 0 && g < 3000);
        chk("frame_timeout", phase, 0);
    endtask

    initial begin
        clear_stats();
        @(negedge aclk);
        chk("reset_ctl", {busy, frame_done, req_valid, m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow_err}, 0);
        chk("reset_data", {req_x, req_y, m_axis_tdata}, 0);
        @(negedge aclk);
        areset = 1'b0;

        // Nominal frame, 3-cycle engine, tready held high.
        lat = 3; rr_mode = 1; tr_mode = 1;
        clear_stats();
        start_frame();
        peek();
        chk("start_busy", busy, 1);
        chk("start_req_valid", req_valid, 1);
        run_until_idle();
        chk("a_reqs", d_reqs, 12);
        chk("a_beats", d_beats, 12);
        chk("a_tuser_mask", tuser_mask, 16'h0001);
        chk("a_tlast_mask", tlast_mask, 16'h0888);
        chk("a_done_pulses", d_done, 1);
        peek();
        chk("a_busy_after", busy, 0);

        // Downstream stall: credits run out, data held.
        lat = 0; rr_mode = 1; tr_mode = 1;
        start_frame();
        for (int g = 0; g < 100 && outs < 2; g++) run_cycle();
        tr_mode = 2;
        repeat (20) run_cycle();
        peek();
        chk("stall_req_valid", req_valid, 0);
        chk("stall_overflow", overflow_err, 0);
        chk("stall_tvalid", m_axis_tvalid, 1);
        tr_mode = 1;
        run_until_idle();

        // Simultaneous request and pop with one credit left.
        lat = 0; rr_mode = 1; tr_mode = 2;
        start_frame();
        for (int g = 0; g < 100 && (reqs - outs) < 7; g++) run_cycle();
        tr_mode = 1;
        run_cycle();
        peek();
        chk("credit1_req_valid", req_valid, 1);
        chk("credit1_req_xy", {req_x, req_y}, {12'd0, 12'd2});
        run_until_idle();

        // Randomized handshakes and engine latency.
        repeat (4) begin
            lat = $urandom_range(0, 4); rr_mode = 0; tr_mode = 0;
            start_frame();
            run_until_idle();
            repeat ($urandom_range(0, 3)) run_cycle();
        end

        // Starts during RUN and during DONE are ignored.
        lat = 2; rr_mode = 0; tr_mode = 0;
        clear_stats();
        start_frame();
        repeat (5) run_cycle();
        start_req = 1;
        run_cycle();
        start_on_done = 1;
        run_until_idle();
        start_on_done = 0;
        repeat (4) run_cycle();
        chk("e_done_pulses", d_done, 1);
        chk("e_beats", d_beats, 12);
        peek();
        chk("e_busy_after", busy, 0);

        // Spurious result into a full FIFO.
        lat = 0; rr_mode = 1; tr_mode = 2;
        start_frame();
        for (int g = 0; g < 100 && occ < D; g++) run_cycle();
        chk("f_fifo_full", occ, D);
        inject = 1;
        run_cycle();
        peek();
        chk("f_overflow_set", overflow_err, 1);
        tr_mode = 1;
        run_until_idle();
        rr_mode = 0; tr_mode = 0;
        start_frame();
        run_until_idle();
        peek();
        chk("f_overflow_sticky", overflow_err, 1);

        // Reset mid-frame with five results buffered.
        lat = 1; rr_mode = 1; tr_mode = 2;
        start_frame();
        for (int g = 0; g < 100 && occ < 5; g++) run_cycle();
        @(posedge aclk);
        #2;
        areset = 1'b1;
        #1;
        chk("g_reset_ctl", {busy, frame_done, req_valid, m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow_err}, 0);
        chk("g_reset_data", {req_x, req_y, m_axis_tdata}, 0);
        phase = 0; reqs = 0; outs = 0; occ = 0; ovf = 0; prev_stall = 0;
        eq_due.delete(); eq_rgb.delete();
        pix_valid = 1'b0; start = 1'b0;
        repeat (2) run_cycle();
        areset = 1'b0;
        rr_mode = 0; tr_mode = 0;
        clear_stats();
        start_frame();
        run_until_idle();
        chk("g_tuser_mask", tuser_mask, 16'h0001);
        chk("g_tlast_mask", tlast_mask, 16'h0888);
        chk("g_beats", d_beats, 12);
        chk("g_overflow_clear", overflow_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
